temp_avg_readout: RTL

- Consumer end of the sample-accumulator interface: counts accumulate strobes (en_sum), captures the running sum after N_SAMPLES strobes, and clears the accumulator.
- Divides the captured sum by N_SAMPLES with a sequential divider and presents the temperature average with a one-cycle valid strobe.
- Sits between the summing datapath and the display/output stage of the temperature-averaging design.

---
 rtl/temp_avg_pkg.sv | 20 ++
 rtl/seq_div_const.sv | 70 +++++++
 rtl/temp_avg_readout.sv | 92 +++++++++
 3 files changed

// File: rtl/temp_avg_pkg.sv
// rtl/temp_avg_pkg.sv - shared types and helpers for the temperature average readout
package temp_avg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_RUN  = 1'b1
    } div_state_t;

    // Wide enough to hold a strobe count of 0..n inclusive.
    function automatic int count_width(input longint n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_div_const.sv
// rtl/seq_div_const.sv - restoring divider by a constant, one quotient bit per cycle
module seq_div_const
    import temp_avg_pkg::*;
#(
    parameter int     SUM_W   = 16,
    parameter longint DIVISOR = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    output logic [SUM_W-1:0] quotient,
    output logic             done,
    output logic             busy
);

    localparam int               ITER_W  = $clog2(SUM_W + 1);
    localparam logic [SUM_W:0]   DIV_EXT = (SUM_W + 1)'(DIVISOR);
    localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(SUM_W - 1);

    div_state_t        state;
    logic [ITER_W-1:0] iter;
    logic [SUM_W-1:0]  rem;
    logic [SUM_W-1:0]  quo;
    logic [SUM_W:0]    trial;
    logic              bit_q;
    logic [SUM_W-1:0]  rem_next;
    logic [SUM_W-1:0]  quo_next;

    // quo doubles as the dividend shift register; quotient bits enter at the bottom.
    always_comb begin
        trial    = {rem, quo[SUM_W-1]};
        bit_q    = (trial >= DIV_EXT);
        rem_next = bit_q ? SUM_W'(trial - DIV_EXT) : trial[SUM_W-1:0];
        quo_next = {quo[SUM_W-2:0], bit_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
            iter  <= '0;
            rem   <= '0;
            quo   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo   <= dividend;
                        rem   <= '0;
                        iter  <= '0;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    rem  <= rem_next;
                    quo  <= quo_next;
                    iter <= iter + ITER_W'(1);
                    if (iter == LAST_IT) state <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // The final quotient is presented during the last iteration so the owner can register it.
    assign busy     = (state == DIV_RUN);
    assign done     = busy && (iter == LAST_IT);
    assign quotient = quo_next;

endmodule

// File: rtl/temp_avg_readout.sv
// rtl/temp_avg_readout.sv - windowed sample capture, divide-by-N and saturating average output
module temp_avg_readout
    import temp_avg_pkg::*;
#(
    parameter int N_SAMPLES = 16,
    parameter int SUM_W     = 16,
    parameter int DATA_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_sum,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              clr_req,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int               CNT_W = count_width(N_SAMPLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_SAMPLES - 1);

    if (N_SAMPLES < 1 || longint'(N_SAMPLES) > ((64'sd1 <<< SUM_W) - 64'sd1)) begin : g_bad_n
        $error("N_SAMPLES out of range for SUM_W");
    end

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic               load;
    logic               div_done;
    logic               div_busy;
    logic [SUM_W-1:0]   quotient;
    logic [DATA_W-1:0]  avg_sat;

    seq_div_const #(
        .SUM_W   (SUM_W),
        .DIVISOR (N_SAMPLES)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst),
        .start    (load),
        .dividend (sum_in),
        .quotient (quotient),
        .done     (div_done),
        .busy     (div_busy)
    );

    if (SUM_W > DATA_W) begin : g_sat
        assign avg_sat = (|quotient[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : quotient[DATA_W-1:0];
    end else begin : g_nosat
        assign avg_sat = DATA_W'(quotient);
    end

    always_comb begin
        state_next = state;
        clr_req    = 1'b1;
        load       = 1'b0;
        case (state)
            IDLE:    state_next = COLLECT;
            COLLECT: begin
                clr_req = 1'b0;
                if (en_sum && count == LAST) state_next = CAPTURE;
            end
            CAPTURE: begin
                // A window finishing while the divider is busy is dropped, not queued.
                load       = !div_busy;
                state_next = COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            avg_out   <= '0;
            avg_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_next;
            avg_valid <= div_done;
            overrun   <= (state == CAPTURE) && div_busy;
            if (div_done) avg_out <= avg_sat;
            if (state != COLLECT) count <= '0;
            else if (en_sum)      count <= count + CNT_W'(1);
        end
    end

    assign busy = div_busy;

endmodule
